// File: rtl/hack_pkg.sv
// Shared types and constants for the instruction fetch path.
package hack_pkg;

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [15:0] INSTR_RESET = 16'h0000;

endpackage

// File: rtl/fetch_timer.sv
// ROM wait-cycle counter; expired is asserted while the count equals TIMEOUT.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-entry cache in front of a handshaked ROM,
// issuing one cpu_en pulse per instruction and faulting on ROM timeout.
module instr_fetch
  import hack_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [14:0] pc,
  output logic        cpu_en,
  output logic [15:0] instruction,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        fault
);

  fetch_state_e state_q;
  logic         cpu_en_q;
  logic         rom_req_q;
  logic         fault_q;
  logic         cache_valid_q;
  logic [14:0]  rom_addr_q;
  logic [14:0]  cache_addr_q;
  logic [15:0]  instr_q;

  logic hit;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign hit = cache_valid_q && (pc == cache_addr_q);

  // The miss cycle is counted too, so the count reaches TIMEOUT in the TIMEOUT-th S_WAIT cycle.
  assign timer_clear = (state_q == S_WAIT) && rom_ack;
  assign timer_en    = ((state_q == S_ADDR) && !hit) ||
                       ((state_q == S_WAIT) && !rom_ack && !timer_expired);

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_ADDR;
      cpu_en_q      <= 1'b0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= 15'd0;
      instr_q       <= INSTR_RESET;
      fault_q       <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= 15'd0;
    end else begin
      cpu_en_q <= 1'b0;
      case (state_q)
        S_ADDR: begin
          if (hit) begin
            cpu_en_q <= 1'b1;
            state_q  <= S_ISSUE;
          end else begin
            rom_addr_q <= pc;
            rom_req_q  <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_ack) begin
            instr_q       <= rom_data;
            cache_addr_q  <= rom_addr_q;
            cache_valid_q <= 1'b1;
            rom_req_q     <= 1'b0;
            cpu_en_q      <= 1'b1;
            state_q       <= S_ISSUE;
          end else if (timer_expired) begin
            rom_req_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= S_FAULT;
          end
        end
        S_ISSUE: begin
          state_q <= S_ADDR;
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
      endcase
    end
  end

  assign cpu_en      = cpu_en_q;
  assign instruction = instr_q;
  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized fetch stream
// checked against a cache/latency model of the fetch rules.
module tb_instr_fetch;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] pc = 15'd0;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = 16'd0;
  logic        cpu_en;
  logic [15:0] instruction;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        fault;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // reference model: one cached word, plus a small ROM image
  bit          mValid = 1'b0;
  logic [14:0] mAddr  = 15'd0;
  logic [15:0] mInstr = 16'h0000;
  logic [15:0] romMem [16];

  instr_fetch #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .instruction(instruction),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Acts as CPU and ROM for one instruction; acks on the lat-th rom_req cycle (never if lat==0).
  task automatic applyStimulus(input logic [14:0] addr, input int lat, input logic [15:0] data,
                               output int cycles, output logic [15:0] instrSeen,
                               output int reqCycles, output bit addrOk, output bit faulted);
    pc        = addr;
    cycles    = 0;
    reqCycles = 0;
    addrOk    = 1'b1;
    faulted   = 1'b0;
    instrSeen = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cycles++;
      if (cpu_en) begin
        instrSeen = instruction;
        rom_ack   = 1'($urandom);
        rom_data  = 16'($urandom);
        return;
      end
      if (fault) begin
        faulted = 1'b1;
        rom_ack = 1'b0;
        return;
      end
      if (rom_req) begin
        reqCycles++;
        if (rom_addr !== addr) addrOk = 1'b0;
        rom_ack  = (reqCycles == lat);
        rom_data = rom_ack ? data : 16'($urandom);
      end else begin
        rom_ack  = 1'($urandom);
        rom_data = 16'($urandom);
      end
    end
    cycles  = -1;
    rom_ack = 1'b0;
  endtask

  // fromIssue: started in the cpu_en cycle of the previous instruction (else right at reset release).
  task automatic doFetch(input string tag, input logic [14:0] addr, input int lat,
                         input logic [15:0] data, input bit fromIssue);
    bit          hit;
    bit          expFault;
    int          expCycles;
    int          expReq;
    logic [15:0] expInstr;
    int          cycles;
    int          reqCycles;
    logic [15:0] instrSeen;
    bit          addrOk;
    bit          faulted;

    hit      = mValid && (mAddr == addr);
    expFault = 1'b0;
    expInstr = mInstr;
    if (hit) begin
      expCycles = 2;
      expReq    = 0;
    end else if (lat >= 1 && lat <= TIMEOUT) begin
      expCycles = lat + 2;
      expReq    = lat;
      expInstr  = data;
    end else begin
      expFault  = 1'b1;
      expCycles = TIMEOUT + 2;
      expReq    = TIMEOUT;
    end
    if (!fromIssue) expCycles = expCycles - 1;

    applyStimulus(addr, lat, data, cycles, instrSeen, reqCycles, addrOk, faulted);

    checkOutput({tag, ".cycles"}, cycles, expCycles);
    checkOutput({tag, ".fault"}, {31'd0, faulted}, {31'd0, expFault});
    checkOutput({tag, ".reqCycles"}, reqCycles, expReq);
    if (!hit) checkOutput({tag, ".romAddrStable"}, {31'd0, addrOk}, 32'd1);
    if (!expFault) checkOutput({tag, ".instr"}, {16'd0, instrSeen}, {16'd0, expInstr});

    if (!hit && !expFault) begin
      mValid = 1'b1;
      mAddr  = addr;
      mInstr = data;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".cpu_en"}, {31'd0, cpu_en}, 32'd0);
    checkOutput({tag, ".rom_req"}, {31'd0, rom_req}, 32'd0);
    checkOutput({tag, ".rom_addr"}, {17'd0, rom_addr}, 32'd0);
    checkOutput({tag, ".instruction"}, {16'd0, instruction}, 32'h0000);
    checkOutput({tag, ".fault"}, {31'd0, fault}, 32'd0);
  endtask

  task automatic modelReset();
    mValid = 1'b0;
    mAddr  = 15'd0;
    mInstr = 16'h0000;
  endtask

  initial begin
    logic [14:0] rpc;
    for (int i = 0; i < 16; i++) romMem[i] = 16'($urandom);

    // reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetValues("reset");
    modelReset();

    // miss with ROM latency 3 straight out of reset
    reset_n = 1'b1;
    doFetch("miss5", 15'd5, 3, 16'hEC10, 1'b0);

    // hits on a held pc
    doFetch("fill7", 15'd7, 2, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) doFetch("hit7", 15'd7, 2, 16'hBEEF, 1'b1);

    // back-to-back single-cycle misses
    doFetch("b2b0", 15'd0, 1, 16'h0A00, 1'b1);
    doFetch("b2b1", 15'd1, 1, 16'h0A01, 1'b1);
    doFetch("b2b2", 15'd2, 1, 16'h0A02, 1'b1);

    // ack lands on the expiry cycle
    doFetch("ackExpiry", 15'd9, TIMEOUT, 16'h5A5A, 1'b1);

    // randomized fetch stream with repeats to exercise the cache
    rpc = 15'd3;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 0) rpc = 15'($urandom_range(15, 0));
      doFetch("rand", rpc, $urandom_range(TIMEOUT, 1), romMem[rpc[3:0]], 1'b1);
    end

    // reset in the middle of a wait, then a stray ack after release
    pc = 15'h100;
    rom_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("midWait.rom_req", {31'd0, rom_req}, 32'd1);
    checkOutput("midWait.rom_addr", {17'd0, rom_addr}, 32'h100);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checkResetValues("midWaitReset");
    modelReset();
    reset_n  = 1'b1;
    rom_ack  = 1'b1;
    rom_data = 16'hDEAD;
    doFetch("afterReset", 15'd3, 2, 16'h0303, 1'b0);

    // timeout with the ROM never answering
    doFetch("timeout", 15'h200, 0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rom_ack  = 1'b1;
      rom_data = 16'($urandom);
      @(negedge clock);
      checkOutput("faultHold.fault", {31'd0, fault}, 32'd1);
      checkOutput("faultHold.rom_req", {31'd0, rom_req}, 32'd0);
      checkOutput("faultHold.cpu_en", {31'd0, cpu_en}, 32'd0);
      checkOutput("faultHold.instr", {16'd0, instruction}, {16'd0, mInstr});
    end
    rom_ack = 1'b0;

    // reset clears the fault and fetching resumes
    reset_n = 1'b0;
    @(negedge clock);
    checkResetValues("faultReset");
    modelReset();
    reset_n = 1'b1;
    doFetch("recover", 15'd4, 1, 16'h0404, 1'b0);
    doFetch("recoverHit", 15'd4, 1, 16'h9999, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
